imm_extend_pipe: RTL and testbench
==================================

// Module: imm_extend_pipe
// PURPOSE
//  Parametrised, registered immediate-extension stage for the MIPS datapath.
//  Converts an IN_WIDTH immediate to OUT_WIDTH in one of four modes:
//  sign, zero, upper (lui) and branch-offset.
//  Sits between decode and execute.
//  Valid/ready handshake plus a 2-entry skid buffer: back-pressure never drops
//  or reorders an immediate.
// PARAMETERS
//  IN_WIDTH   16  immediate width
//  OUT_WIDTH  32  extended width; OUT_WIDTH < IN_WIDTH+2 -> elaboration error ($error)
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          synchronous, active-high
//  in_valid   in   1          in_imm/in_mode valid
//  in_ready   out  1          stage can accept; transfer when in_valid & in_ready
//  in_mode    in   2          00 sign, 01 zero, 10 upper, 11 branch
//  in_imm     in   IN_WIDTH   raw immediate
//  out_valid  out  1          out_data valid
//  out_ready  in   1          consumer accepts; transfer when out_valid & out_ready
//  out_data   out  OUT_WIDTH  extended immediate
//  xfer_count out  16         only with IMMEXT_COUNT_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (sync, active-high, sampled on clk):
//   - out_valid=0, out_data=0, in_ready=1, skid empty, state EMPTY.
//   - Reset wins over any simultaneous handshake.
//  Extension (s = in_imm[IN_WIDTH-1], P = OUT_WIDTH-IN_WIDTH):
//   - sign:   {P{s}, imm}
//   - zero:   {P{0}, imm}
//   - upper:  {imm, P{0}}
//   - branch: ({P{s}, imm} << 2); top bits are discarded, low 2 bits are 0.
//  Extension is computed at input acceptance; the extended word is stored,
//  not the raw imm.
//  Latency: accepted in cycle N -> out_valid with data in cycle N+1 when not
//  stalled.
//  FSM (in_ready and out_valid are registered, from state only):
//   - EMPTY: in_ready=1, out_valid=0.
//       accept -> ONE.
//   - ONE: in_ready=1, out_valid=1.
//       accept & out xfer -> ONE (output reg reloads).
//       accept & no out xfer -> FULL (new word into skid).
//       no accept & out xfer -> EMPTY.
//       neither -> ONE.
//   - FULL: in_ready=0, out_valid=1.
//       out xfer -> ONE (skid moves to output reg).
//       otherwise hold.
//  Handshake rules:
//   - out_data/out_valid are stable while out_valid & !out_ready.
//   - in_valid while in_ready=0 is ignored (no capture).
//  Order: strictly FIFO; at most 2 words in flight.
//  Mid-operation reset discards both entries; nothing is emitted afterward.
//  in_mode is decoded fully; there are no illegal encodings.
// CONFIGURATION
//  Macro IMMEXT_COUNT_EN:
//   - Defined: adds port xfer_count (16-bit).
//       +1 on each output transfer; wraps 0xFFFF -> 0x0000; reset to 0.
//   - Undefined: port and counter are absent; all other behaviour identical.
// STRUCTURE
//  Package imm_extend_pkg:
//   - mode localparams MODE_SIGN=2'b00, MODE_ZERO=2'b01, MODE_UPPER=2'b10,
//     MODE_BRANCH=2'b11
//   - FSM state encoding ST_EMPTY, ST_ONE, ST_FULL
//  Sub-module imm_extend_core:
//   - purely combinational; params IN_WIDTH/OUT_WIDTH; (mode, imm) -> word.
//  Top holds the FSM, output register, skid register and optional counter.
// TESTING (IN_WIDTH=16, OUT_WIDTH=32)
//  1. sign 0x8001 -> 0xFFFF8001 and zero 0x8001 -> 0x00008001,
//     each one cycle after accept, out_ready=1.
//  2. upper 0x1234 -> 0x12340000; branch 0xFFFF -> 0xFFFFFFFC;
//     branch 0x0004 -> 0x00000010.
//  3. out_ready=0, offer A, B, C back-to-back:
//     - A and B accepted; in_ready=0 from the cycle after B; C held.
//     - Release out_ready: A, B, C emitted in order, no loss or duplicate.
//  4. out_ready toggling every cycle with continuous in_valid for 100 random
//     words: scoreboard matches; out_data stable during every stall.
//  5. Reset asserted in FULL:
//     - next cycle out_valid=0, in_ready=1, out_data=0.
//     - Pre-reset words never appear.
//  6. With IMMEXT_COUNT_EN and counter preloaded near 0xFFFF via 65535
//     transfers: one more transfer -> xfer_count=0x0000; reset -> 0.

Source files
------------

// File: rtl/imm_extend_pkg.sv
// rtl/imm_extend_pkg.sv - shared mode encodings and stage FSM states for the immediate-extension pipe
package imm_extend_pkg;

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

endpackage

// File: rtl/imm_extend_core.sv
// rtl/imm_extend_core.sv - combinational sign/zero/upper/branch immediate extender
module imm_extend_core
    import imm_extend_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic [1:0]           i_mode,
    input  logic [IN_WIDTH-1:0]  i_imm,
    output logic [OUT_WIDTH-1:0] o_word
);

    localparam int P = OUT_WIDTH - IN_WIDTH;

    logic                 w_sign;
    logic [OUT_WIDTH-1:0] w_sext;

    assign w_sign = i_imm[IN_WIDTH-1];
    assign w_sext = {{P{w_sign}}, i_imm};

    // Branch offset is the sign-extended word shifted left by two; top bits fall off.
    always_comb begin
        o_word = w_sext;
        case (i_mode)
            MODE_SIGN:   o_word = w_sext;
            MODE_ZERO:   o_word = {{P{1'b0}}, i_imm};
            MODE_UPPER:  o_word = {i_imm, {P{1'b0}}};
            MODE_BRANCH: o_word = {w_sext[OUT_WIDTH-3:0], 2'b00};
            default:     o_word = w_sext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - registered immediate-extension stage with valid/ready and 2-entry skid
// Optional transfer counter port xfer_count enabled by macro IMMEXT_COUNT_EN.
module imm_extend_pipe
    import imm_extend_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_mode,
    input  logic [IN_WIDTH-1:0]  in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data
`ifdef IMMEXT_COUNT_EN
    ,
    output logic [15:0]          xfer_count
`endif
);

    generate
        if (OUT_WIDTH < IN_WIDTH + 2) begin : g_width_check
            $error("imm_extend_pipe: OUT_WIDTH must be at least IN_WIDTH+2");
        end
    endgenerate

    state_t               r_state;
    state_t               w_next_state;
    logic [OUT_WIDTH-1:0] r_out_data;
    logic [OUT_WIDTH-1:0] r_skid;
    logic [OUT_WIDTH-1:0] w_ext;
    logic                 w_accept;
    logic                 w_out_xfer;
    logic                 w_load_out_ext;
    logic                 w_load_out_skid;
    logic                 w_load_skid;

    imm_extend_core #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_core (
        .i_mode (in_mode),
        .i_imm  (in_imm),
        .o_word (w_ext)
    );

    // Handshake outputs decode only the state register, never the inputs.
    assign in_ready   = (r_state != ST_FULL);
    assign out_valid  = (r_state != ST_EMPTY);
    assign out_data   = r_out_data;
    assign w_accept   = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    always_comb begin
        w_next_state    = r_state;
        w_load_out_ext  = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_next_state   = ST_ONE;
                    w_load_out_ext = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_out_xfer) begin
                    w_load_out_ext = 1'b1;
                end else if (w_accept) begin
                    w_next_state = ST_FULL;
                    w_load_skid  = 1'b1;
                end else if (w_out_xfer) begin
                    w_next_state = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_xfer) begin
                    w_next_state    = ST_ONE;
                    w_load_out_skid = 1'b1;
                end
            end
            default: w_next_state = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_out_data <= '0;
            r_skid     <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load_out_ext) begin
                r_out_data <= w_ext;
            end else if (w_load_out_skid) begin
                r_out_data <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_ext;
            end
        end
    end

`ifdef IMMEXT_COUNT_EN
    logic [15:0] r_xfer_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_xfer_count <= 16'h0000;
        end else if (w_out_xfer) begin
            r_xfer_count <= r_xfer_count + 16'h0001;
        end
    end

    assign xfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - scoreboard bench for imm_extend_pipe (16 -> 32)
module tb_imm_extend_pipe;
    import imm_extend_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [15:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef IMMEXT_COUNT_EN
    logic [15:0] xfer_count;
`endif

    int          n_vec  = 0;
    int          n_miss = 0;
    int          n_out  = 0;
    logic [31:0] exp_q[$];
    logic        held = 1'b0;
    logic [31:0] held_data = '0;
    logic        t4_done = 1'b0;

    always #5 clk = ~clk;

    imm_extend_pipe #(
        .IN_WIDTH  (16),
        .OUT_WIDTH (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef IMMEXT_COUNT_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] m, input logic [15:0] v);
        logic signed [31:0] sx;
        sx = 32'($signed(v));
        case (m)
            2'b00:   model = sx;
            2'b01:   model = {16'h0000, v};
            2'b10:   model = {v, 16'h0000};
            default: model = sx * 4;
        endcase
    endfunction

    // Scoreboard and stall-stability monitor, sampled on the falling edge.
    always @(negedge clk) begin : mon
        logic [31:0] e;
        if (reset) begin
            exp_q.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                check_vec("stall_valid", {31'b0, out_valid}, 32'h1);
                check_vec("stall_data", out_data, held_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_vec("spurious_out", out_data, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    check_vec("out_data", out_data, e);
                end
                n_out++;
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_mode, in_imm));
            held      = out_valid && !out_ready;
            held_data = out_data;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [1:0] m, input logic [15:0] v);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_imm   = v;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check_vec("send_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_check(input string tag, input logic [1:0] m, input logic [15:0] v,
                              input logic [31:0] expv);
        send(m, v);
        @(negedge clk);
        check_vec({tag, "_valid"}, {31'b0, out_valid}, 32'h1);
        check_vec({tag, "_data"}, out_data, expv);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int t;
        t         = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0 || out_valid) check_vec("drain_timeout", 32'h0, 32'h1);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int base;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_mode   = 2'b00;
        in_imm    = '0;
        do_reset();
        @(negedge clk);
        check_vec("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check_vec("rst_in_ready", {31'b0, in_ready}, 32'h1);
        check_vec("rst_out_data", out_data, 32'h0);
        @(posedge clk);
        #1;

        // Directed extension vectors, one cycle after acceptance.
        send_check("t1_sign", MODE_SIGN, 16'h8001, 32'hFFFF8001);
        send_check("t1_zero", MODE_ZERO, 16'h8001, 32'h00008001);
        send_check("t2_upper", MODE_UPPER, 16'h1234, 32'h12340000);
        send_check("t2_br_neg", MODE_BRANCH, 16'hFFFF, 32'hFFFFFFFC);
        send_check("t2_br_pos", MODE_BRANCH, 16'h0004, 32'h00000010);
        wait_drain();

        // Back-pressure: A and B fill the stage, C must wait.
        base      = n_out;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = MODE_SIGN;
        in_imm    = 16'h8A0A;
        @(negedge clk);
        check_vec("t3_a_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        in_mode = MODE_ZERO;
        in_imm  = 16'h0B0B;
        @(negedge clk);
        check_vec("t3_b_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        in_mode = MODE_UPPER;
        in_imm  = 16'h0C0C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_vec("t3_full_ready", {31'b0, in_ready}, 32'h0);
            check_vec("t3_hold_a", out_data, 32'hFFFF8A0A);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) check_vec("t3_c_timeout", 32'h0, 32'h1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain();
        check_vec("t3_count", 32'(n_out - base), 32'd3);

        // Random stream against a toggling consumer.
        base      = n_out;
        out_ready = 1'b0;
        t4_done   = 1'b0;
        fork
            begin
                for (int i = 0; i < 100; i++) send(2'($urandom_range(0, 3)), 16'($urandom));
                t4_done = 1'b1;
            end
            begin
                while (!t4_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ~out_ready;
                end
            end
        join
        wait_drain();
        check_vec("t4_count", 32'(n_out - base), 32'd100);

        // Reset while FULL discards both held words.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = MODE_SIGN;
        in_imm    = 16'h1111;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_imm = 16'h2222;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_imm = 16'h3333;
        @(negedge clk);
        check_vec("t5_full", {31'b0, in_ready}, 32'h0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_vec("t5_out_valid", {31'b0, out_valid}, 32'h0);
        check_vec("t5_in_ready", {31'b0, in_ready}, 32'h1);
        check_vec("t5_out_data", out_data, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_vec("t5_idle", {31'b0, out_valid}, 32'h0);
        end
        @(posedge clk);
        #1;

`ifdef IMMEXT_COUNT_EN
        do_reset();
        @(negedge clk);
        check_vec("t6_cnt_rst", {16'h0, xfer_count}, 32'h0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) send(MODE_ZERO, 16'(i));
        wait_drain();
        check_vec("t6_cnt_ffff", {16'h0, xfer_count}, 32'h0000FFFF);
        send(MODE_SIGN, 16'h7FFF);
        wait_drain();
        check_vec("t6_cnt_wrap", {16'h0, xfer_count}, 32'h0);
        send(MODE_SIGN, 16'h0001);
        wait_drain();
        do_reset();
        @(negedge clk);
        check_vec("t6_cnt_rst2", {16'h0, xfer_count}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
